// File: rtl/ysyx_24100005_imem_responder.sv
// Instruction-memory responder: the memory end of the fetch path.
// One fetch is outstanding at a time. The response is captured at accept
// and returned after LATENCY cycles over a valid/ready channel.
// Misaligned or out-of-range fetches return ebreak with resp_err set.
module ysyx_24100005_imem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_inst,
  output logic                     resp_err,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_idx,
  input  logic [31:0]              prog_data
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic [31:0]   off;
  logic          addr_ok;
  logic [AW-1:0] rd_idx;
  logic [31:0]   prog_idx_ext;

  // Address decode: wrap-around offset makes below-base addresses out of range
  always_comb begin
    off          = req_addr - BASE_ADDR;
    addr_ok      = (req_addr[1:0] == 2'b00) && (off < SPAN);
    rd_idx       = off[AW+1:2];
    prog_idx_ext = 32'(prog_idx);
  end

  // Program-store write port; indices past DEPTH are dropped
  always_ff @(posedge clk) begin
    if (rst && prog_we && (prog_idx_ext < DEPTH)) begin
      mem[prog_idx] <= prog_data;
    end
  end

  // Request/response sequencing with registered handshake outputs.
  // The store is read at the accept edge, so a same-edge write to the same
  // word is not seen by this fetch (the write lands via non-blocking update).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_inst  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            resp_inst <= addr_ok ? mem[rd_idx] : EBREAK;
            resp_err  <= !addr_ok;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
